param_bus_mux: RTL
==================

// Module: param_bus_mux
// PURPOSE
//   Parametrised, registered datapath bus: N source registers, each WIDTH bits, share one bus.
//   One-hot "out" enables from the control unit select the driving source.
//   Adds what the plain bus lacks: a registered output stage, encoded select index,
//   multi-driver conflict detection, an idle hold/zero mode and a transfer counter.
//   Sits between the register file/special registers (HI, LO, Z, PC, MDR, port, C) and all bus consumers.
// PARAMETERS
//   N_SRC      24   number of bus sources (2..32)
//   WIDTH      32   bus data width in bits
//   HOLD_IDLE  1    1: bus keeps last value when no enable is set; 0: bus drives 0
//   CNT_W      16   width of the transfer counter
// PORTS
//   clk           in   1              system clock, rising edge
//   clr_n         in   1              asynchronous active-low reset
//   src_data      in   N_SRC*WIDTH    packed source values; source i at [i*WIDTH +: WIDTH]
//   src_out       in   N_SRC          one-hot output enables; bit i = source i drives
//   conflict_clr  in   1              synchronous clear of conflict_sticky
//   bus_out       out  WIDTH          registered bus value
//   bus_valid     out  1              bus_out was driven by a source in the previous cycle
//   sel_idx       out  $clog2(N_SRC)  index of the source that drove bus_out
//   conflict      out  1              more than one enable was set in the previous cycle
//   conflict_sticky out 1             latched conflict flag
//   xfer_count    out  CNT_W          number of valid transfers since reset
// BEHAVIOUR
//   - Reset (clr_n=0, asynchronous, any time): all outputs = 0 and the hold register = 0.
//     Reset during a transfer drops that transfer; the counter is not incremented.
//   - Latency: src_out/src_data sampled at a rising edge appear on the outputs after that edge (1 cycle).
//   - Per edge, with E = src_out:
//     * popcount(E)==1: bus_out<=src_data[i], sel_idx<=i, bus_valid<=1, conflict<=0.
//     * popcount(E)>1: the lowest set index wins (bus_out, sel_idx as above).
//       bus_valid<=1, conflict<=1 (single-cycle pulse per offending cycle).
//     * E==0: bus_valid<=0, conflict<=0, sel_idx holds its last value.
//       bus_out holds its last value if HOLD_IDLE=1, else bus_out<=0.
//   - conflict_sticky: set on any edge where popcount(E)>1.
//     Cleared by conflict_clr=1 only when no new conflict occurs that cycle (set wins).
//   - xfer_count: +1 on every edge where E!=0. Wraps modulo 2^CNT_W with no flag.
//   - Pure function of E and src_data; no internal FSM beyond the output/hold registers.
//     Consecutive back-to-back transfers from different sources are sustained every cycle.
//   - sel_idx is zero-extended; unused encodings (N_SRC not a power of 2) never appear.
// TESTING (N_SRC=24, WIDTH=32, HOLD_IDLE=1, CNT_W=16 unless stated)
//   1 Reset: clr_n=0 mid-cycle with E=0x000002 -> all outputs 0 immediately, xfer_count=0.
//   2 Single driver: src1=0x0000_0012, E=0x000002 -> next cycle bus_out=0x12, sel_idx=1,
//     bus_valid=1, conflict=0, xfer_count=1.
//   3 Conflict: src3=0xAAAA_AAAA, src5=0x5555_5555, E=0x000028 -> bus_out=0xAAAAAAAA,
//     sel_idx=3, conflict=1 for one cycle, conflict_sticky=1.
//     Then conflict_clr=1 with E=0x000028 -> sticky stays 1; with E=0x000001 -> sticky 0.
//   4 Idle: after test 2 set E=0 -> bus_out stays 0x12, bus_valid=0.
//     Rerun with HOLD_IDLE=0 -> bus_out=0.
//   5 Top source/back-to-back: E=0x800000 (src23=0xDEADBEEF), then E=0x000001 (src0=7)
//     on consecutive edges -> bus_out 0xDEADBEEF then 7, sel_idx 23 then 0.
//   6 Wrap: CNT_W=4, 17 consecutive valid cycles -> xfer_count reads 1.

Source files
------------

// File: rtl/param_bus_mux_if.sv
// Shared datapath bus bundle: source values and enables in, registered bus view out.
interface param_bus_mux_if #(
    parameter int unsigned N_SRC = 24,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC*WIDTH-1:0] src_data;
    logic [N_SRC-1:0]       src_out;
    logic                   conflict_clr;
    logic [WIDTH-1:0]       bus_out;
    logic                   bus_valid;
    logic [IDX_W-1:0]       sel_idx;
    logic                   conflict;
    logic                   conflict_sticky;
    logic [CNT_W-1:0]       xfer_count;

    // Control unit / register file side
    modport master (
        output src_data, src_out, conflict_clr,
        input  bus_out, bus_valid, sel_idx, conflict, conflict_sticky, xfer_count
    );

    // Bus multiplexer side
    modport slave (
        input  src_data, src_out, conflict_clr,
        output bus_out, bus_valid, sel_idx, conflict, conflict_sticky, xfer_count
    );
endinterface

// File: rtl/param_bus_mux.sv
// Registered shared datapath bus: lowest-index enabled source drives bus_out one
// cycle later, with encoded select, multi-driver detection and a transfer counter.
module param_bus_mux #(
    parameter int unsigned N_SRC     = 24,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned HOLD_IDLE = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               clr_n,
    param_bus_mux_if.slave     bus
);
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic                   hit_c;
    logic                   multi_c;
    logic [IDX_W-1:0]       win_idx_c;
    logic [WIDTH-1:0]       win_data_c;

    logic [WIDTH-1:0]       bus_out_n;
    logic                   bus_valid_n;
    logic [IDX_W-1:0]       sel_idx_n;
    logic                   conflict_n;
    logic                   sticky_n;
    logic [CNT_W-1:0]       count_n;

    // Priority select: scan downward so the lowest enabled source wins
    always_comb begin
        hit_c      = 1'b0;
        win_idx_c  = '0;
        win_data_c = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (bus.src_out[i]) begin
                hit_c      = 1'b1;
                win_idx_c  = IDX_W'(i);
                win_data_c = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
        // More than one bit set iff clearing the lowest set bit leaves something
        multi_c = (bus.src_out & (bus.src_out - N_SRC'(1))) != '0;
    end

    // Next values for the output/hold registers
    always_comb begin
        bus_out_n   = (HOLD_IDLE != 0) ? bus.bus_out : '0;
        bus_valid_n = 1'b0;
        sel_idx_n   = bus.sel_idx;
        conflict_n  = multi_c;
        count_n     = bus.xfer_count;
        sticky_n    = bus.conflict_sticky;

        if (hit_c) begin
            bus_out_n   = win_data_c;
            bus_valid_n = 1'b1;
            sel_idx_n   = win_idx_c;
            count_n     = bus.xfer_count + CNT_W'(1);
        end

        // A fresh conflict overrides a clear request in the same cycle
        if (multi_c) begin
            sticky_n = 1'b1;
        end else if (bus.conflict_clr) begin
            sticky_n = 1'b0;
        end
    end

    // Output registers; asynchronous reset drops any in-flight transfer
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus.bus_out         <= '0;
            bus.bus_valid       <= 1'b0;
            bus.sel_idx         <= '0;
            bus.conflict        <= 1'b0;
            bus.conflict_sticky <= 1'b0;
            bus.xfer_count      <= '0;
        end else begin
            bus.bus_out         <= bus_out_n;
            bus.bus_valid       <= bus_valid_n;
            bus.sel_idx         <= sel_idx_n;
            bus.conflict        <= conflict_n;
            bus.conflict_sticky <= sticky_n;
            bus.xfer_count      <= count_n;
        end
    end
endmodule
